// File: rtl/mem_pkg.sv
// Shared types and address helpers for the data memory responder.
package mem_pkg;

  localparam int unsigned WORD_W = 32;

  typedef enum logic {
    IDLE,
    WAIT
  } load_state_e;

  // Byte address to word index. The caller keeps the low bits that match its depth.
  function automatic logic [WORD_W-1:0] addr_to_index(input logic [WORD_W-1:0] addr);
    return {2'b00, addr[WORD_W-1:2]};
  endfunction

  function automatic logic is_misaligned(input logic [WORD_W-1:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/store_buffer.sv
// Posted-store FIFO of {index, data} with a youngest-match forwarding lookup.
module store_buffer #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned IDX_W  = 10,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [IDX_W-1:0]  push_idx,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [IDX_W-1:0]  head_idx,
  output logic [DATA_W-1:0] head_data,
  output logic              full,
  output logic              empty,
  input  logic [IDX_W-1:0]  lookup_idx,
  output logic              lookup_hit,
  output logic [DATA_W-1:0] lookup_data
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [IDX_W-1:0]  idx_mem_q  [DEPTH];
  logic [DATA_W-1:0] data_mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  lookup_pos;

  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);
  assign head_idx  = idx_mem_q[rd_ptr_q];
  assign head_data = data_mem_q[rd_ptr_q];

  // Pointer and occupancy bookkeeping; push and pop together keep the count.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Scan oldest to youngest so the last match found is the youngest store.
  always_comb begin
    lookup_hit  = 1'b0;
    lookup_data = '0;
    lookup_pos  = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      lookup_pos = rd_ptr_q + PTR_W'(i);
      if ((CNT_W'(i) < count_q) && (idx_mem_q[lookup_pos] == lookup_idx)) begin
        lookup_hit  = 1'b1;
        lookup_data = data_mem_q[lookup_pos];
      end
    end
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents need no reset because occupancy gates every use.
  always_ff @(posedge clk) begin
    if (push) begin
      idx_mem_q[wr_ptr_q]  <= push_idx;
      data_mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Word data memory with posted stores, fixed-latency loads and store forwarding.
import mem_pkg::*;

module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS  = 1024,
  parameter int unsigned WB_DEPTH     = 4,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memoryWrite,
  input  logic        memoryRead,
  input  logic [31:0] memoryAddressOut,
  input  logic [31:0] memoryDataOut,
  output logic        memoryReady,
  output logic        memoryReadValid,
  output logic [31:0] memoryReadData,
  output logic        memoryFault
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam int unsigned LAT_W = $clog2(READ_LATENCY + 1);

  logic [WORD_W-1:0] mem_q [DEPTH_WORDS];

  logic [WORD_W-1:0] addr_word;
  logic [IDX_W-1:0]  req_idx;
  logic              misaligned;
  logic              req_accepted;
  logic              store_go;
  logic              load_go;
  logic [WORD_W-1:0] load_value;
  logic              unused_addr_bits;

  logic              sb_full, sb_empty, sb_pop, fwd_hit;
  logic [IDX_W-1:0]  sb_head_idx;
  logic [WORD_W-1:0] sb_head_data, fwd_data;

  load_state_e       state_q, state_d;
  logic [LAT_W-1:0]  cnt_q, cnt_d;
  logic [WORD_W-1:0] capt_q, capt_d;
  logic [WORD_W-1:0] rdata_q, rdata_d;
  logic              valid_q, valid_d;
  logic              fault_q, fault_d;

  assign addr_word        = addr_to_index(memoryAddressOut);
  assign req_idx          = addr_word[IDX_W-1:0];
  assign unused_addr_bits = ^addr_word[WORD_W-1:IDX_W];
  assign misaligned       = is_misaligned(memoryAddressOut);

  assign memoryReady  = !sb_full && (state_q == IDLE);
  // A simultaneous read and write is treated as a store only.
  assign req_accepted = memoryReady && (memoryWrite || memoryRead);
  assign store_go     = memoryReady && memoryWrite && !misaligned;
  assign load_go      = memoryReady && memoryRead && !memoryWrite && !misaligned;
  assign sb_pop       = !sb_empty && !load_go;
  assign load_value   = fwd_hit ? fwd_data : mem_q[req_idx];

  store_buffer #(
    .DEPTH  (WB_DEPTH),
    .IDX_W  (IDX_W),
    .DATA_W (WORD_W)
  ) u_store_buffer (
    .clk         (clk),
    .rst         (rst),
    .push        (store_go),
    .push_idx    (req_idx),
    .push_data   (memoryDataOut),
    .pop         (sb_pop),
    .head_idx    (sb_head_idx),
    .head_data   (sb_head_data),
    .full        (sb_full),
    .empty       (sb_empty),
    .lookup_idx  (req_idx),
    .lookup_hit  (fwd_hit),
    .lookup_data (fwd_data)
  );

  // Drain the oldest buffered store; suppressed under reset so pending stores are discarded.
  always_ff @(posedge clk) begin
    if (!rst && sb_pop) mem_q[sb_head_idx] <= sb_head_data;
  end

  // Load FSM next state: valid is raised one cycle early so the output is registered.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capt_d  = capt_q;
    valid_d = 1'b0;
    rdata_d = '0;
    fault_d = req_accepted && misaligned;
    case (state_q)
      IDLE: begin
        if (load_go) begin
          state_d = WAIT;
          cnt_d   = LAT_W'(READ_LATENCY - 1);
          capt_d  = load_value;
          if (READ_LATENCY == 1) begin
            valid_d = 1'b1;
            rdata_d = load_value;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - LAT_W'(1);
          if (cnt_q == LAT_W'(1)) begin
            valid_d = 1'b1;
            rdata_d = capt_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Load FSM and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      capt_q  <= '0;
      rdata_q <= '0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      capt_q  <= capt_d;
      rdata_q <= rdata_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
    end
  end

  assign memoryReadValid = valid_q;
  assign memoryReadData  = rdata_q;
  assign memoryFault     = fault_q;

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Word-organised data memory that answers the execute stage's memory port. It accepts stores through a small posted write buffer and loads with a fixed read latency, forwarding from buffered stores. Backpressure is a single ready signal. It sits between execute and the memory-stage writeback path, alongside the register file.

## Interface
- `DEPTH_WORDS`, 1024: number of 32-bit words; power of two.
- `WB_DEPTH`, 4: store-buffer entries; power of two, ≥2.
- `READ_LATENCY`, 2: cycles from load acceptance to `memoryReadValid`; ≥1.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `memoryWrite` in 1: store request.
- `memoryRead` in 1: load request.
- `memoryAddressOut` in 32: byte address from execute.
- `memoryDataOut` in 32: store data.
- `memoryReady` out 1: request is accepted this cycle if asserted.
- `memoryReadValid` out 1: one-cycle pulse, load data valid.
- `memoryReadData` out 32: load result; 0 when not valid.
- `memoryFault` out 1: one-cycle pulse, misaligned request dropped.

## Operation
- Word index is `addr[log2(DEPTH_WORDS)+1:2]`. Upper address bits are ignored, so addresses wrap modulo `DEPTH_WORDS*4`.
- If `addr[1:0]` ≠ 0 on an accepted request, the request is dropped and `memoryFault` pulses the next cycle. Nothing is stored or returned.
- `memoryReady` = (buffer count < `WB_DEPTH`) AND load FSM in IDLE. It is combinational from registered state only, with no dependence on request inputs.
- Store, accepted with `memoryWrite & memoryReady`: the {index, data} pair is pushed to the tail of the store buffer.
- Load, accepted with `memoryRead & memoryReady & ~memoryWrite`:
  - If `memoryWrite` and `memoryRead` are both asserted, only the store is accepted. The load must be re-presented.
  - On acceptance, data is captured from the youngest buffer entry with a matching index if one exists, otherwise from the array.
  - The captured value is returned after `READ_LATENCY` cycles.
- Drain: in any cycle with no load accepted and buffer not empty, the oldest entry is written to the array and popped. Push and pop may occur in the same cycle, leaving the count unchanged.
- Load FSM:
  - IDLE → WAIT on load acceptance, with latency counter = `READ_LATENCY`-1.
  - WAIT decrements the counter each cycle. At 0 it asserts `memoryReadValid`/`memoryReadData` and returns to IDLE.
  - With `READ_LATENCY`=1, WAIT lasts exactly one cycle.
- Array contents are not reset. Reads of never-written words return whatever the array holds; the bench preloads the array.

## Timing
- Reset values: `memoryReady` 1 in the cycle after reset deasserts. `memoryReadValid` 0, `memoryReadData` 0, `memoryFault` 0. Buffer count 0, FSM IDLE.
- Reset mid-operation: buffered undrained stores are discarded and any in-flight load is cancelled, with no valid pulse.
- Load accepted at cycle T: valid at T+`READ_LATENCY`. The next load can be accepted at T+`READ_LATENCY`+1. Stores are also blocked during WAIT.
- Store accepted at T: visible to loads accepted at T+1 or later, via forwarding or the array.
- Buffer full at T: `memoryReady`=0 at T even if a drain occurs at T. Ready returns at T+1.
- Back-to-back stores with no loads: the buffer never fills, because each cycle pushes one entry and pops one.

## Structure
- Package `mem_pkg`:
  - `WORD_W`=32
  - load FSM state typedef {IDLE, WAIT}
  - `addr_to_index` / misalignment helper function
- Sub-module `store_buffer`: parameterised FIFO holding {index, data}.
  - Push, pop, count and full/empty.
  - Combinational youngest-match lookup port (hit, data) for forwarding.
- Top-level responsibilities:
  - array
  - load FSM and latency counter
  - ready/fault logic

## Test plan
- Store 0x0000_1234 to 0x40, then idle 6 cycles, then load 0x40 → `memoryReadValid` exactly 2 cycles after acceptance, data 0x0000_1234, ready low for those 2 cycles.
- Stores 0x11 and then 0x22 to 0x80 on consecutive cycles, then load 0x80 on the next cycle → forwarded 0x22, not 0x11 and not stale array data.
- Hold loads continuously (one accepted every 3 cycles) while issuing 4 stores → stores wait for ready, `memoryReady`=0 once 4 are buffered, and no store is lost. Final loads return all 4 values.
- `memoryRead` and `memoryWrite` both high to 0x10 with data 0xAA → store only, no valid pulse. A re-presented load returns 0xAA.
- Load to 0x42 → `memoryFault` pulses once, no `memoryReadValid`, and the FSM stays IDLE. Store to 0x1003 (with `DEPTH_WORDS`=1024) → `memoryFault` pulses and the array is unchanged.
- Load accepted, then `rst` asserted one cycle later → no valid pulse. After reset the outputs are 0 and `memoryReady`=1, and pending buffered stores are absent from the array.
